stoch_to_bin: RTL
=================

# stoch_to_bin

Stochastic-to-binary converter that sits directly downstream of the cascaded gate stages (XOR/AND trees) in the stochastic network datapath. It counts the ones in a single-bit stochastic stream over a fixed window of 2^WBITS sample periods. It then presents the result as a binary value, unipolar or bipolar, through a valid/ready hold register. Typical consumers are neuron activation lookups and result capture logic.

## Interface
- WBITS, 8: log2 of the window length; window = 2^WBITS qualified samples.
- BIPOLAR, 0: 0 = unipolar output (count of ones); 1 = bipolar output (2*ones − 2^WBITS, two's complement).
- CLK  input  1  single clock; all state changes on rising edge.
- RST  input  1  reset, asynchronous, active-high; clears all state immediately.
- EN  input  1  sample qualifier; IN is counted only on cycles with EN=1.
- IN  input  1  stochastic bitstream from the upstream gate cascade.
- START  input  1  begin a new window (single-cycle pulse).
- READY  input  1  downstream accepts OUT when VALID=1.
- OUT  output  WBITS+2  converted value; unipolar zero-extended, bipolar signed.
- VALID  output  1  OUT holds a completed window result.
- BUSY  output  1  window accumulation in progress.

## Operation
- States: IDLE, ACCUM, HOLD.
- IDLE:
  - START=1 → ACCUM; sample counter and ones counter cleared.
  - IN on the START cycle is not counted.
- ACCUM:
  - Each cycle with EN=1: sample counter +1, ones counter +IN.
  - EN=0 cycles change nothing.
  - START=1 in ACCUM restarts the window: both counters cleared and that cycle's sample discarded, regardless of EN.
  - RST has priority over everything.
- Window end:
  - The cycle on which EN=1 and the sample counter equals 2^WBITS−1 is the last sample, and that sample is included.
  - Next state is HOLD. OUT is registered from the final ones count, including the last bit. VALID is set.
- Ones counter:
  - WBITS+1 bits, so a full window of ones (2^WBITS) does not wrap.
  - The sample counter is WBITS bits and wraps only at window end.
- Arithmetic:
  - Unipolar: OUT = ones, range 0..2^WBITS.
  - Bipolar: OUT = (ones<<1) − 2^WBITS, range −2^WBITS..+2^WBITS, computed in WBITS+2 bits.
- HOLD:
  - OUT and VALID are stable; IN and EN are ignored.
  - READY=1 completes the transfer: VALID falls next cycle.
  - If START=1 on the same cycle, next state is ACCUM with counters cleared (back-to-back windows); otherwise IDLE.
  - START without READY in HOLD is ignored.
- BUSY = 1 exactly in ACCUM.
- OUT keeps its last value after the transfer until the next window completes.

## Timing
- Reset values: OUT=0, VALID=0, BUSY=0, state IDLE, both counters 0.
- RST asserted mid-window or in HOLD: outputs cleared asynchronously and the partial result is lost. After release, the block waits in IDLE for START.
- START at cycle t: BUSY=1 from t+1. The first counted sample is at t+1 or later.
- Last qualified sample at cycle s: VALID=1 and OUT valid from s+1; BUSY=0 from s+1.
- With EN held high, VALID rises 2^WBITS+1 cycles after the START cycle.
- READY=1 at cycle h with VALID=1: VALID=0 from h+1. READY is not registered, so a single-cycle accept works.
- Back-to-back: READY&START at h → BUSY=1 at h+1. Minimum spacing between VALID pulses is 2^WBITS+1 cycles.
- READY while VALID=0 has no effect.

## Structure
- Shared package stoch_pkg:
  - state encoding (IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2);
  - a function computing the bipolar offset 2^WBITS at width WBITS+2;
  - reused by the upstream stochastic number generator and other converters.
- One sub-module, sc_window_ctr:
  - the WBITS-bit qualified sample counter, with clear, enable and a last-sample flag (EN & count==2^WBITS−1);
  - this counter is shared with the stochastic number generator's period counter.
- The FSM, ones counter and output register live in stoch_to_bin.

## Test plan
- WBITS=4, BIPOLAR=0: START, then 16 cycles with EN=1 and IN=1 on 6 of them → VALID on the 17th cycle after START, OUT=6, BUSY low the same cycle.
- WBITS=4, unipolar:
  - IN=1 for all 16 samples → OUT=16, no wrap.
  - All zeros → OUT=0.
- WBITS=4, BIPOLAR=1:
  - 12 ones of 16 → OUT=+8.
  - 0 ones → OUT=−16 (6'b110000).
  - 8 ones → OUT=0.
- EN gaps: 16 EN=1 samples spread over 30 cycles, with IN=1 also driven on EN=0 cycles → only qualified ones counted; VALID one cycle after the 16th EN=1 sample.
- Hold and handshake:
  - READY low 5 cycles after VALID → OUT and VALID stable, IN toggling ignored.
  - READY&START together → VALID low and BUSY high the next cycle; the second window's result is independent of the first.
- RST at sample 9 of a window → OUT, VALID and BUSY = 0 immediately. A following START yields a full fresh 16-sample result; START mid-ACCUM discards the prior partial count.

Source files
------------

// File: rtl/stoch_pkg.sv
// Shared definitions for the stochastic datapath: FSM encoding and bipolar offset helper.
package stoch_pkg;

    localparam int unsigned OFFSET_W = 34;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } stoch_state_e;

    // 2^wbits; callers cast down to their own WBITS+2 output width
    function automatic logic [OFFSET_W-1:0] bipolar_offset(input int unsigned wbits);
        return OFFSET_W'(1) << wbits;
    endfunction

endpackage

// File: rtl/sc_window_ctr.sv
// Qualified sample counter over a 2^WBITS window with a last-sample flag.
module sc_window_ctr
    import stoch_pkg::*;
#(
    parameter int unsigned WBITS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last_c
);

    localparam logic [WBITS-1:0] CNT_LAST = '1;

    logic [WBITS-1:0] cnt;

    // wraps naturally back to zero on the last sample of a window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + WBITS'(1);
        end
    end

    assign last_c = en && (cnt == CNT_LAST);

endmodule

// File: rtl/stoch_to_bin.sv
// Counts ones of a stochastic stream over a 2^WBITS window and hands the result out via valid/ready.
module stoch_to_bin
    import stoch_pkg::*;
#(
    parameter int unsigned WBITS   = 8,
    parameter int unsigned BIPOLAR = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             IN,
    input  logic             START,
    input  logic             READY,
    output logic [WBITS+1:0] OUT,
    output logic             VALID,
    output logic             BUSY
);

    localparam int unsigned ONES_W = WBITS + 1;
    localparam int unsigned OUT_W  = WBITS + 2;
    localparam logic [OUT_W-1:0] OFFSET = OUT_W'(bipolar_offset(WBITS));

    stoch_state_e      state;
    logic [ONES_W-1:0] ones;
    logic [ONES_W-1:0] ones_next_c;
    logic [OUT_W-1:0]  result_c;
    logic              ctr_clr_c;
    logic              ctr_en_c;
    logic              win_last_c;

    // counter clears whenever a window (re)starts; samples on START cycles are dropped
    assign ctr_clr_c = START && ((state == ST_IDLE) || (state == ST_ACCUM) ||
                                 ((state == ST_HOLD) && READY));
    assign ctr_en_c  = (state == ST_ACCUM) && EN && !START;

    sc_window_ctr #(
        .WBITS (WBITS)
    ) u_window_ctr (
        .clk    (CLK),
        .rst    (RST),
        .clr    (ctr_clr_c),
        .en     (ctr_en_c),
        .last_c (win_last_c)
    );

    // final count includes the current sample so the last bit is not lost
    always_comb begin
        ones_next_c = ones + ONES_W'(IN);
        result_c    = OUT_W'(ones_next_c);
        if (BIPOLAR != 0) begin
            result_c = (OUT_W'(ones_next_c) << 1) - OFFSET;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
            ones  <= '0;
            OUT   <= '0;
            VALID <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        state <= ST_ACCUM;
                        ones  <= '0;
                        BUSY  <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (START) begin
                        ones <= '0;
                    end else if (EN) begin
                        if (win_last_c) begin
                            state <= ST_HOLD;
                            ones  <= '0;
                            OUT   <= result_c;
                            VALID <= 1'b1;
                            BUSY  <= 1'b0;
                        end else begin
                            ones <= ones_next_c;
                        end
                    end
                end
                ST_HOLD: begin
                    if (READY) begin
                        VALID <= 1'b0;
                        if (START) begin
                            state <= ST_ACCUM;
                            ones  <= '0;
                            BUSY  <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ones  <= '0;
                    VALID <= 1'b0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
